// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the 8N1 UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK_WAIT
   } rx_state_t;

   localparam int DATA_BITS = 8;

   // Width of a counter that must reach clocks_per_bit-1.
   function automatic int cnt_width(input int clocks_per_bit);
      return (clocks_per_bit > 2) ? $clog2(clocks_per_bit) : 1;
   endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte handshake and status between the UART receiver and its consumer.
interface uart_receiver_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] RxData;
   logic                 data_ready;
   logic                 rx_ack;
   logic                 framing_error;
   logic                 overrun;
   logic                 busy;

   modport master (
      output RxData,
      output data_ready,
      output framing_error,
      output overrun,
      output busy,
      input  rx_ack
   );

   modport slave (
      input  RxData,
      input  data_ready,
      input  framing_error,
      input  overrun,
      input  busy,
      output rx_ack
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic rx_in,
   output logic rx_s
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= rx_in;
         sync_q <= meta_q;
      end
   end

   assign rx_s = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 serial receiver: mid-bit sampling FSM with ready/ack byte handshake,
// framing-error pulse and sticky overrun flag.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int clk_freq  = 50_000_000,
   parameter int baud_rate = 115200
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            RxD,
   uart_receiver_if.master rx_if
);

   localparam int div_counter = clk_freq / baud_rate;
   localparam int half_div    = div_counter / 2;
   localparam int CNT_W       = cnt_width(div_counter);
   localparam int IDX_W       = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(div_counter - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(half_div - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic rx_s;

   uart_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .rx_in (RxD),
      .rx_s  (rx_s)
   );

   rx_state_t            state_q,         state_d;
   logic [CNT_W-1:0]     cnt_q,           cnt_d;
   logic [IDX_W-1:0]     bit_idx_q,       bit_idx_d;
   logic [DATA_BITS-1:0] shift_q,         shift_d;
   logic [DATA_BITS-1:0] rx_data_q,       rx_data_d;
   logic                 data_ready_q,    data_ready_d;
   logic                 framing_error_q, framing_error_d;
   logic                 overrun_q,       overrun_d;
   logic                 busy_q,          busy_d;

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      bit_idx_d       = bit_idx_q;
      shift_d         = shift_q;
      rx_data_d       = rx_data_q;
      data_ready_d    = data_ready_q;
      framing_error_d = 1'b0;
      overrun_d       = overrun_q;
      busy_d          = busy_q;

      // Ack clears first so a same-cycle set condition below takes priority.
      if (rx_if.rx_ack) begin
         data_ready_d = 1'b0;
         overrun_d    = 1'b0;
      end

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end

         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (bit_idx_q == IDX_LAST) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  if (!data_ready_q || rx_if.rx_ack) begin
                     rx_data_d    = shift_q;
                     data_ready_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  framing_error_d = 1'b1;
                  state_d         = BREAK_WAIT;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // A held-low line must return high before a new start bit counts.
         BREAK_WAIT: begin
            if (rx_s) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         bit_idx_q       <= '0;
         shift_q         <= '0;
         rx_data_q       <= '0;
         data_ready_q    <= 1'b0;
         framing_error_q <= 1'b0;
         overrun_q       <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         bit_idx_q       <= bit_idx_d;
         shift_q         <= shift_d;
         rx_data_q       <= rx_data_d;
         data_ready_q    <= data_ready_d;
         framing_error_q <= framing_error_d;
         overrun_q       <= overrun_d;
         busy_q          <= busy_d;
      end
   end

   assign rx_if.RxData        = rx_data_q;
   assign rx_if.data_ready    = data_ready_q;
   assign rx_if.framing_error = framing_error_q;
   assign rx_if.overrun       = overrun_q;
   assign rx_if.busy          = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

   localparam int CLK_FREQ = 1600;
   localparam int BAUD     = 100;
   localparam int DIV      = 16;

   logic clk = 1'b0;
   logic reset;
   logic RxD;

   int vectors     = 0;
   int miscompares = 0;

   uart_receiver_if rx_if ();

   uart_receiver #(
      .clk_freq  (CLK_FREQ),
      .baud_rate (BAUD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .RxD   (RxD),
      .rx_if (rx_if)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input int stop_cycles, input logic stop_level);
      RxD = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         tick(DIV);
      end
      RxD = stop_level;
      tick(stop_cycles);
      RxD = 1'b1;
   endtask

   task automatic pulse_ack;
      rx_if.rx_ack = 1'b1;
      tick(1);
      rx_if.rx_ack = 1'b0;
   endtask

   task automatic watch(input int cycles, output int fe_cycles, output int busy_cycles);
      fe_cycles   = 0;
      busy_cycles = 0;
      for (int i = 0; i < cycles; i++) begin
         tick(1);
         if (rx_if.framing_error) fe_cycles++;
         if (rx_if.busy) busy_cycles++;
      end
   endtask

   task automatic wait_ready(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (rx_if.data_ready) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      RxD = 1'b1;
      rx_if.rx_ack = 1'b0;
      tick(3);
      vectors++;
      if (rx_if.RxData !== 8'h00) begin miscompares++; $display("FAIL reset_rxdata: got %02h want 00", rx_if.RxData); end
      vectors++;
      if (rx_if.data_ready !== 1'b0) begin miscompares++; $display("FAIL reset_data_ready: got %b want 0", rx_if.data_ready); end
      vectors++;
      if (rx_if.framing_error !== 1'b0) begin miscompares++; $display("FAIL reset_framing_error: got %b want 0", rx_if.framing_error); end
      vectors++;
      if (rx_if.overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", rx_if.overrun); end
      vectors++;
      if (rx_if.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", rx_if.busy); end
      reset = 1'b0;
      tick(5);
      $display("reset: outputs checked after reset");
   endtask

   task automatic test_single;
      int n;
      int fe_seen;
      bit ok;
      n = 0; fe_seen = 0; ok = 1'b0;
      fork
         send_frame(8'hA5, DIV, 1'b1);
         begin
            for (int i = 0; i < 400; i++) begin
               tick(1);
               n++;
               if (rx_if.framing_error) fe_seen++;
               if (rx_if.data_ready) begin
                  ok = 1'b1;
                  break;
               end
            end
         end
      join
      tick(4);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL single_timeout: data_ready never rose within 400 cycles"); end
      vectors++;
      if (n !== 155) begin miscompares++; $display("FAIL single_latency: got %0d cycles want 155", n); end
      vectors++;
      if (rx_if.RxData !== 8'hA5) begin miscompares++; $display("FAIL single_rxdata: got %02h want a5", rx_if.RxData); end
      vectors++;
      if (fe_seen !== 0) begin miscompares++; $display("FAIL single_framing: got %0d pulses want 0", fe_seen); end
      vectors++;
      if (rx_if.busy !== 1'b0) begin miscompares++; $display("FAIL single_busy: got %b want 0", rx_if.busy); end
      $display("single: byte a5 received after %0d cycles", n);
   endtask

   task automatic test_reset_midframe;
      logic [7:0] b;
      int fe_c, busy_c;
      b = 8'h3C;
      RxD = 1'b0;
      tick(DIV);
      for (int i = 0; i < 4; i++) begin
         RxD = b[i];
         tick(DIV);
      end
      RxD = b[4];
      tick(DIV / 2);
      reset = 1'b1;
      RxD = 1'b1;
      tick(2);
      vectors++;
      if (rx_if.RxData !== 8'h00) begin miscompares++; $display("FAIL midreset_rxdata: got %02h want 00", rx_if.RxData); end
      vectors++;
      if (rx_if.data_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_data_ready: got %b want 0", rx_if.data_ready); end
      vectors++;
      if (rx_if.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", rx_if.busy); end
      reset = 1'b0;
      tick(10);
      fork
         send_frame(8'h81, DIV, 1'b1);
         watch(170, fe_c, busy_c);
      join
      vectors++;
      if (rx_if.RxData !== 8'h81) begin miscompares++; $display("FAIL midreset_rxdata_after: got %02h want 81", rx_if.RxData); end
      vectors++;
      if (rx_if.data_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready_after: got %b want 1", rx_if.data_ready); end
      vectors++;
      if (fe_c !== 0 || rx_if.overrun !== 1'b0) begin miscompares++; $display("FAIL midreset_flags: got fe=%0d ovr=%b want 0/0", fe_c, rx_if.overrun); end
      pulse_ack;
      vectors++;
      if (rx_if.data_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_ack: got %b want 0", rx_if.data_ready); end
      $display("reset_midframe: 3c aborted, 81 received");
   endtask

   task automatic test_glitch;
      int fe_c, busy_c;
      RxD = 1'b0;
      fork
         begin
            tick(5);
            RxD = 1'b1;
         end
         watch(30, fe_c, busy_c);
      join
      vectors++;
      if (busy_c !== 8) begin miscompares++; $display("FAIL glitch_busy_pulse: got %0d cycles want 8", busy_c); end
      vectors++;
      if (rx_if.busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_end: got %b want 0", rx_if.busy); end
      vectors++;
      if (rx_if.data_ready !== 1'b0) begin miscompares++; $display("FAIL glitch_data_ready: got %b want 0", rx_if.data_ready); end
      vectors++;
      if (fe_c !== 0 || rx_if.overrun !== 1'b0) begin miscompares++; $display("FAIL glitch_flags: got fe=%0d ovr=%b want 0/0", fe_c, rx_if.overrun); end
      $display("glitch: busy high for %0d cycles", busy_c);
   endtask

   task automatic test_framing;
      int fe_c, busy_c;
      fork
         send_frame(8'h55, 40, 1'b0);
         watch(200, fe_c, busy_c);
      join
      vectors++;
      if (fe_c !== 1) begin miscompares++; $display("FAIL framing_pulse: got %0d cycles want 1", fe_c); end
      vectors++;
      if (busy_c !== 184) begin miscompares++; $display("FAIL framing_busy: got %0d cycles want 184", busy_c); end
      vectors++;
      if (rx_if.data_ready !== 1'b0) begin miscompares++; $display("FAIL framing_data_ready: got %b want 0", rx_if.data_ready); end
      vectors++;
      if (rx_if.RxData !== 8'h81) begin miscompares++; $display("FAIL framing_rxdata: got %02h want 81", rx_if.RxData); end
      tick(5);
      $display("framing: fe pulses=%0d busy cycles=%0d", fe_c, busy_c);
   endtask

   task automatic test_overrun;
      send_frame(8'h11, DIV, 1'b1);
      tick(4);
      vectors++;
      if (rx_if.RxData !== 8'h11 || rx_if.data_ready !== 1'b1) begin miscompares++; $display("FAIL overrun_first: got %02h/%b want 11/1", rx_if.RxData, rx_if.data_ready); end
      send_frame(8'h22, DIV, 1'b1);
      tick(4);
      vectors++;
      if (rx_if.RxData !== 8'h11) begin miscompares++; $display("FAIL overrun_rxdata: got %02h want 11", rx_if.RxData); end
      vectors++;
      if (rx_if.overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b want 1", rx_if.overrun); end
      pulse_ack;
      vectors++;
      if (rx_if.data_ready !== 1'b0) begin miscompares++; $display("FAIL overrun_ack_ready: got %b want 0", rx_if.data_ready); end
      vectors++;
      if (rx_if.overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_ack_clear: got %b want 0", rx_if.overrun); end
      $display("overrun: 22 dropped, flag cleared by ack");
   endtask

   task automatic test_back_to_back;
      logic [7:0] bytes [5];
      int fe_c, busy_c;
      bit ok;
      bytes = '{8'h00, 8'hFF, 8'h5A, 8'hC3, 8'h01};
      fork
         begin
            for (int k = 0; k < 5; k++) send_frame(bytes[k], DIV, 1'b1);
         end
         begin
            for (int k = 0; k < 5; k++) begin
               wait_ready(400, ok);
               vectors++;
               if (!ok) begin miscompares++; $display("FAIL b2b_timeout: byte %0d never arrived", k); end
               vectors++;
               if (rx_if.RxData !== bytes[k]) begin miscompares++; $display("FAIL b2b_rxdata: byte %0d got %02h want %02h", k, rx_if.RxData, bytes[k]); end
               $display("back_to_back: byte %0d = %02h", k, rx_if.RxData);
               tick(3);
               pulse_ack;
            end
         end
         watch(5 * 10 * DIV + 20, fe_c, busy_c);
      join
      vectors++;
      if (fe_c !== 0 || rx_if.overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_flags: got fe=%0d ovr=%b want 0/0", fe_c, rx_if.overrun); end
      vectors++;
      if (rx_if.data_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_end: got %b want 0", rx_if.data_ready); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      RxD = 1'b1;
      rx_if.rx_ack = 1'b0;
      test_reset;
      test_single;
      test_reset_midframe;
      test_glitch;
      test_framing;
      test_overrun;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel receive stage: consumes the asynchronous 8N1 line driven by the UART transmitter (idle-high, start bit, 8 data bits LSB-first, stop bit).
- Synchronises the line, validates the start bit at mid-bit, and samples each bit at its centre.
- Presents the received byte with a ready/ack handshake to the downstream consumer.
- Flags framing errors and overruns.

Parameters:
- clk_freq, 50_000_000, system clock frequency in Hz.
- baud_rate, 115200, line bit rate.
- div_counter (localparam), clk_freq/baud_rate, clocks per bit (434 at defaults). Must be >= 4.
- half_div (localparam), div_counter/2, clocks to the start-bit centre (217 at defaults).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- RxD  input  1  asynchronous serial line, idle high.
- rx_ack  input  1  consumer has taken RxData; clears data_ready.
- RxData  output  8  last correctly framed byte.
- data_ready  output  1  RxData holds an unacknowledged byte.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: byte dropped because data_ready was still high.
- busy  output  1  high from start-bit detection until the frame ends.

Behaviour:
- Reset: applied on the clk edge only while reset=1; wins over everything, including mid-frame.
  - State to IDLE; both synchroniser flops to 1.
  - RxData=0, data_ready=0, framing_error=0, overrun=0, busy=0; counters and shift register cleared.
- Synchroniser: two flops, RxD to rx_s. All decisions use rx_s only, giving 2 cycles of latency from the pin.
- Bit counter: width $clog2(div_counter). Bit index: 0..7.
- IDLE:
  - busy=0. If rx_s==0: go to START, counter=0, busy=1.
- START: counter increments each cycle. At counter==half_div-1:
  - rx_s==0: go to DATA, counter=0, bit index=0.
  - rx_s==1: glitch; go to IDLE, busy=0, no flags.
- DATA: counter increments each cycle. At counter==div_counter-1:
  - Counter resets to 0 and rx_s shifts into the MSB of the shift register (right shift), so bit 0 ends at the LSB.
  - After the 8th sample, go to STOP.
- STOP: at counter==div_counter-1, sample rx_s.
  - rx_s==1, data_ready==0 or rx_ack==1: RxData<=shift, data_ready<=1. Go to IDLE, busy<=0.
  - rx_s==1, data_ready==1 and rx_ack==0: RxData unchanged, overrun<=1. Go to IDLE, busy<=0.
  - rx_s==0: framing_error pulses for exactly 1 cycle; RxData and data_ready unchanged. Go to BREAK_WAIT; busy stays 1.
- BREAK_WAIT: stays until rx_s==1, then goes to IDLE with busy=0. This prevents a held-low line (break) from retriggering.
- Latency: the stop-bit sample edge is half_div + 9*div_counter cycles after the edge on which IDLE sees rx_s==0. data_ready is visible the cycle after that edge. At defaults this is 4123 cycles.
- Handshake:
  - rx_ack while data_ready==1 clears data_ready next cycle.
  - rx_ack with data_ready==0 is ignored.
  - If rx_ack coincides with a good stop sample, the new byte loads and data_ready stays 1.
- overrun: cleared by rx_ack. If a set condition and rx_ack occur in the same cycle, set wins.
- Back-to-back frames: a start bit immediately after the stop sample is detected from IDLE with no lost frame. Because sampling is at mid-stop-bit, there is half a bit of margin.

Decomposition:
- uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK_WAIT}.
  - Constant DATA_BITS=8.
  - Function computing the counter width from the clocks-per-bit value.
- Sub-module uart_rx_sync: 2-flop synchroniser with synchronous reset to 1.
- FSM, counters, and output registers stay in uart_receiver.

Test Plan:
All scenarios use clk_freq=1600, baud_rate=100, so div_counter=16 and half_div=8.
- Reset mid-frame: drive 0x3C, assert reset during bit 4, then send 0x81 -> all outputs 0 after reset; RxData=0x81, data_ready=1; no error flags.
- Single byte 0xA5 at ideal timing -> data_ready rises exactly 8+9*16+1 cycles after rx_s first low (plus 2 sync cycles from the pin); RxData=0xA5; framing_error=0.
- Glitch: RxD low for 5 cycles, then high -> no state change beyond START; busy pulses; data_ready=0; no flags.
- Framing error: send 0x55 with stop bit held low for 40 cycles, then high -> one-cycle framing_error; data_ready=0; busy low only after the line returns high.
- Overrun: send 0x11, do not ack, send 0x22 -> RxData=0x11, overrun=1. Then pulse rx_ack -> data_ready=0, overrun=0.
- Loopback with the UART transmitter at defaults: 256 bytes 0x00..0xFF back-to-back, acking each within 10 cycles -> all received in order, zero errors.
